nts_api_bus_bridge: RTL and testbench



---
 rtl/nts_api_bus_bridge.sv | 111 +++++++++++
 tb/tb_nts_api_bus_bridge.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nts_api_bus_bridge.sv
// Host bus to NTS API decoder bridge: one registered chip-select transaction per
// accepted request, with read-latency hold, read-data capture and range checking.
module nts_api_bus_bridge #(
  parameter logic [11:0] ADDR_LAST    = 12'h1FF,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic        i_clk,
  input  logic        i_areset,
  input  logic        i_bus_req,
  input  logic        i_bus_we,
  input  logic [11:0] i_bus_addr,
  input  logic [31:0] i_bus_wdata,
  output logic        o_bus_busy,
  output logic        o_bus_ack,
  output logic        o_bus_err,
  output logic [31:0] o_bus_rdata,
  output logic [15:0] o_err_count,
  output logic        o_api_cs,
  output logic        o_api_we,
  output logic [11:0] o_api_address,
  output logic [31:0] o_api_write_data,
  input  logic [31:0] i_api_read_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;

  logic [1:0] state;
  logic       we_q;
  logic       err_q;
  logic [2:0] wait_cnt;
  logic       addr_bad;

  assign addr_bad = (i_bus_addr > ADDR_LAST);

  // cs/we are registered one state ahead so they are high exactly during ISSUE/WAIT.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state            <= IDLE;
      we_q             <= 1'b0;
      err_q            <= 1'b0;
      wait_cnt         <= '0;
      o_bus_busy       <= 1'b0;
      o_bus_ack        <= 1'b0;
      o_bus_err        <= 1'b0;
      o_bus_rdata      <= '0;
      o_err_count      <= '0;
      o_api_cs         <= 1'b0;
      o_api_we         <= 1'b0;
      o_api_address    <= '0;
      o_api_write_data <= '0;
    end else begin
      o_bus_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (i_bus_req) begin
            we_q             <= i_bus_we;
            err_q            <= addr_bad;
            o_api_address    <= i_bus_addr;
            o_api_write_data <= i_bus_wdata;
            o_api_cs         <= !addr_bad;
            o_api_we         <= i_bus_we && !addr_bad;
            o_bus_busy       <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= 3'(READ_LATENCY);
          if (err_q) begin
            if (o_err_count != 16'hFFFF)
              o_err_count <= o_err_count + 16'd1;
            if (!we_q)
              o_bus_rdata <= '0;
            o_bus_ack <= 1'b1;
            o_bus_err <= 1'b1;
            state     <= ACK;
          end else if (we_q || READ_LATENCY == 0) begin
            if (!we_q)
              o_bus_rdata <= i_api_read_data;
            o_api_cs  <= 1'b0;
            o_api_we  <= 1'b0;
            o_bus_ack <= 1'b1;
            o_bus_err <= 1'b0;
            state     <= ACK;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 3'd1) begin
            o_bus_rdata <= i_api_read_data;
            o_api_cs    <= 1'b0;
            o_bus_ack   <= 1'b1;
            o_bus_err   <= 1'b0;
            state       <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: begin
          o_bus_err  <= 1'b0;
          o_bus_busy <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nts_api_bus_bridge.sv
// Randomized bench for nts_api_bus_bridge at read latencies 0 and 3, checked every
// cycle against a transaction-timeline model plus literal directed expectations.
module tb_nts_api_bus_bridge;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        i_areset, i_bus_req, i_bus_we;
  logic [11:0] i_bus_addr;
  logic [31:0] i_bus_wdata, i_api_read_data;

  logic [1:0]  busy, ack, berr, cs, awe;
  logic [31:0] rdata [2];
  logic [31:0] wdat  [2];
  logic [11:0] aaddr [2];
  logic [15:0] ecnt  [2];

  nts_api_bus_bridge #(.ADDR_LAST(12'h1FF), .READ_LATENCY(0)) dut0 (
    .i_clk(i_clk), .i_areset(i_areset), .i_bus_req(i_bus_req), .i_bus_we(i_bus_we),
    .i_bus_addr(i_bus_addr), .i_bus_wdata(i_bus_wdata), .o_bus_busy(busy[0]),
    .o_bus_ack(ack[0]), .o_bus_err(berr[0]), .o_bus_rdata(rdata[0]),
    .o_err_count(ecnt[0]), .o_api_cs(cs[0]), .o_api_we(awe[0]),
    .o_api_address(aaddr[0]), .o_api_write_data(wdat[0]), .i_api_read_data(i_api_read_data));

  nts_api_bus_bridge #(.ADDR_LAST(12'h1FF), .READ_LATENCY(3)) dut3 (
    .i_clk(i_clk), .i_areset(i_areset), .i_bus_req(i_bus_req), .i_bus_we(i_bus_we),
    .i_bus_addr(i_bus_addr), .i_bus_wdata(i_bus_wdata), .o_bus_busy(busy[1]),
    .o_bus_ack(ack[1]), .o_bus_err(berr[1]), .o_bus_rdata(rdata[1]),
    .o_err_count(ecnt[1]), .o_api_cs(cs[1]), .o_api_we(awe[1]),
    .o_api_address(aaddr[1]), .o_api_write_data(wdat[1]), .i_api_read_data(i_api_read_data));

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d at %0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  // Model: k = cycle offset since acceptance (0 = idle); the whole timeline follows from k.
  int          k      [2];
  bit          m_we   [2];
  bit          m_err  [2];
  logic [11:0] m_addr [2];
  logic [31:0] m_wdata[2];
  logic [31:0] m_rdata[2];
  int unsigned m_ecnt [2];

  function automatic int lat(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int dur(input int d);
    return (m_we[d] || m_err[d]) ? 2 : 2 + lat(d);
  endfunction

  always @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      for (int d = 0; d < 2; d++) begin
        k[d] = 0; m_we[d] = 0; m_err[d] = 0; m_addr[d] = '0;
        m_wdata[d] = '0; m_rdata[d] = '0; m_ecnt[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (k[d] == 0) begin
          if (i_bus_req) begin
            m_we[d] = i_bus_we; m_err[d] = (i_bus_addr > 12'h1FF);
            m_addr[d] = i_bus_addr; m_wdata[d] = i_bus_wdata; k[d] = 1;
          end
        end else begin
          if (k[d] == 1 && m_err[d]) begin
            if (m_ecnt[d] != 65535) m_ecnt[d]++;
            if (!m_we[d]) m_rdata[d] = '0;
          end
          if (!m_err[d] && !m_we[d] && k[d] == 1 + lat(d)) m_rdata[d] = i_api_read_data;
          if (k[d] == dur(d)) k[d] = 0; else k[d]++;
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        bit e_ack, e_cs;
        e_ack = (k[d] != 0) && (k[d] == dur(d));
        e_cs  = !m_err[d] && k[d] >= 1 && k[d] <= (m_we[d] ? 1 : 1 + lat(d));
        check("busy",  d, 32'(busy[d]), 32'(k[d] != 0));
        check("ack",   d, 32'(ack[d]),  32'(e_ack));
        check("err",   d, 32'(berr[d]), 32'(e_ack && m_err[d]));
        check("cs",    d, 32'(cs[d]),   32'(e_cs));
        check("we",    d, 32'(awe[d]),  32'(e_cs && m_we[d]));
        check("addr",  d, 32'(aaddr[d]), 32'(m_addr[d]));
        check("wdata", d, wdat[d],  m_wdata[d]);
        check("rdata", d, rdata[d], m_rdata[d]);
        check("ecnt",  d, 32'(ecnt[d]), m_ecnt[d]);
      end
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #2;
  endtask

  task automatic req(input logic we, input logic [11:0] a, input logic [31:0] w);
    i_bus_req = 1'b1; i_bus_we = we; i_bus_addr = a; i_bus_wdata = w;
  endtask

  initial begin
    i_areset = 1'b0; i_bus_req = 1'b0; i_bus_we = 1'b0;
    i_bus_addr = '0; i_bus_wdata = '0; i_api_read_data = '0;
    #1 i_areset = 1'b1;
    #1 chk_en = 1'b1;
    tick; tick;
    for (int d = 0; d < 2; d++) begin
      check("rst_busy", d, 32'(busy[d]), 32'd0);
      check("rst_cs",   d, 32'(cs[d]),   32'd0);
      check("rst_ecnt", d, 32'(ecnt[d]), 32'd0);
      check("rst_rdata", d, rdata[d], 32'd0);
    end
    i_areset = 1'b0;

    // write
    tick; req(1'b1, 12'h010, 32'hCAFEBABE);
    tick; i_bus_req = 1'b0;
    check("wr_cs", 0, 32'(cs[0]), 32'd1);
    check("wr_we", 0, 32'(awe[0]), 32'd1);
    check("wr_addr", 1, 32'(aaddr[1]), 32'h010);
    check("wr_data", 1, wdat[1], 32'hCAFEBABE);
    tick;
    check("wr_ack", 0, 32'(ack[0]), 32'd1);
    check("wr_cs_off", 1, 32'(cs[1]), 32'd0);

    // read: dut0 samples during T0+1, dut3 during T0+4
    tick; req(1'b0, 12'h0A0, 32'h0);
    tick; i_bus_req = 1'b0; i_api_read_data = 32'h12345678;
    tick; i_api_read_data = 32'h0;
    check("rd0_ack", 0, 32'(ack[0]), 32'd1);
    check("rd0_data", 0, rdata[0], 32'h12345678);
    tick; check("rd3_cs", 1, 32'(cs[1]), 32'd1);
    tick; i_api_read_data = 32'hA5A5A5A5;
    check("rd3_cs_last", 1, 32'(cs[1]), 32'd1);
    tick; i_api_read_data = 32'h0;
    check("rd3_ack", 1, 32'(ack[1]), 32'd1);
    check("rd3_data", 1, rdata[1], 32'hA5A5A5A5);
    tick;

    // out of range read
    req(1'b0, 12'h200, 32'h0);
    tick; i_bus_req = 1'b0;
    tick;
    for (int d = 0; d < 2; d++) begin
      check("oor_err", d, 32'(berr[d]), 32'd1);
      check("oor_rdata", d, rdata[d], 32'd0);
      check("oor_ecnt", d, 32'(ecnt[d]), 32'd1);
    end
    tick;

    // request while busy is dropped
    req(1'b1, 12'h020, 32'h11112222);
    tick; req(1'b0, 12'h030, 32'h0);
    tick; i_bus_req = 1'b0;
    check("busy_addr", 0, 32'(aaddr[0]), 32'h020);
    tick; tick;
    check("busy_nocs", 0, 32'(cs[0]), 32'd0);
    check("busy_idle", 1, 32'(busy[1]), 32'd0);

    // async reset during dut3 WAIT
    req(1'b0, 12'h040, 32'h0);
    tick; i_bus_req = 1'b0;
    tick; #2 i_areset = 1'b1;
    #1;
    check("arst_cs", 1, 32'(cs[1]), 32'd0);
    check("arst_ack", 1, 32'(ack[1]), 32'd0);
    tick; tick; i_areset = 1'b0;
    tick;
    check("arst_idle", 1, 32'(busy[1]), 32'd0);

    // saturation of the reject counter
    force dut0.o_err_count = 16'hFFFF;
    m_ecnt[0] = 65535;
    #1 release dut0.o_err_count;
    for (int i = 0; i < 2; i++) begin
      tick; req(1'b1, 12'hFFF, 32'h0);
      tick; i_bus_req = 1'b0;
      tick; tick;
    end
    check("sat_ecnt", 0, 32'(ecnt[0]), 32'h0000FFFF);
    check("sat_ecnt3", 1, 32'(ecnt[1]), 32'd2);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      tick;
      if ($urandom_range(0, 599) == 0) begin
        i_areset = 1'b1;
      end else begin
        i_areset = 1'b0;
        i_bus_req   = ($urandom_range(0, 2) == 0);
        i_bus_we    = $urandom_range(0, 1) == 1;
        i_bus_addr  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : {3'b000, 9'($urandom)};
        i_bus_wdata = $urandom;
      end
      i_api_read_data = $urandom;
    end
    i_areset = 1'b0; i_bus_req = 1'b0;
    tick; tick; tick; tick; tick; tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
